// File: rtl/ptp_pkg.sv
// ptp_pkg: shared constants, reject codes and FSM encoding for the Pdelay path
package ptp_pkg;
    localparam int unsigned NS_PER_SEC = 1_000_000_000;
    localparam logic [1:0] REJ_NONE   = 2'b00;
    localparam logic [1:0] REJ_NEG    = 2'b01;
    localparam logic [1:0] REJ_THRESH = 2'b10;
    localparam logic [1:0] REJ_RANGE  = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_DIFF, S_NORM, S_CHK, S_FILT} state_t;
endpackage

// File: rtl/ptp_pdelay_calc_if.sv
// ptp_pdelay_calc_if: timestamp/result bus between the PTP register list and the delay calculator
interface ptp_pdelay_calc_if #(parameter int TIMESTAMP_WIDTH = 80);
    logic [TIMESTAMP_WIDTH-1:0] i_pdelay_t0;
    logic [TIMESTAMP_WIDTH-1:0] i_pdelay_t1;
    logic [TIMESTAMP_WIDTH-1:0] i_pdelay_t2;
    logic [TIMESTAMP_WIDTH-1:0] i_pdelay_t3;
    logic i_pdelaytime_valid;
    logic [31:0] o_pdelay_time;
    logic o_pdelay_time_valid;
    logic [31:0] o_raw_delay;
    logic o_sample_reject;
    logic [1:0] o_reject_code;
    logic o_as_capable;
    logic o_overrun;
    logic o_busy;
    modport master (
        output i_pdelay_t0, i_pdelay_t1, i_pdelay_t2, i_pdelay_t3, i_pdelaytime_valid,
        input o_pdelay_time, o_pdelay_time_valid, o_raw_delay, o_sample_reject,
        input o_reject_code, o_as_capable, o_overrun, o_busy
    );
    modport slave (
        input i_pdelay_t0, i_pdelay_t1, i_pdelay_t2, i_pdelay_t3, i_pdelaytime_valid,
        output o_pdelay_time, o_pdelay_time_valid, o_raw_delay, o_sample_reject,
        output o_reject_code, o_as_capable, o_overrun, o_busy
    );
endinterface

// File: rtl/ptp_ts_diff_ns.sv
// ptp_ts_diff_ns: late-minus-early timestamp difference in signed ns, two-cycle registered latency
module ptp_ts_diff_ns
    import ptp_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = 80
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [TIMESTAMP_WIDTH-1:0] i_ts_late,
    input  logic [TIMESTAMP_WIDTH-1:0] i_ts_early,
    output logic signed [32:0]         o_ns,
    output logic                       o_range_err
);
    localparam int SW = TIMESTAMP_WIDTH - 32;
    localparam logic signed [32:0] NS_SEC = 33'(NS_PER_SEC);
    logic [SW-1:0] r_sd, w_sd;
    logic signed [32:0] r_nd, w_nd, r_ns, w_ns;
    logic r_err, w_err, w_pos, w_neg;
    // seconds/ns differences and the +-1 s fold into ns; only sd in {-1,0,+1} is representable
    always_comb begin
        w_sd  = i_ts_late[TIMESTAMP_WIDTH-1:32] - i_ts_early[TIMESTAMP_WIDTH-1:32];
        w_nd  = {1'b0, i_ts_late[31:0]} - {1'b0, i_ts_early[31:0]};
        w_pos = r_sd == SW'(1);
        w_neg = r_sd == '1;
        w_ns  = w_pos ? r_nd + NS_SEC : w_neg ? r_nd - NS_SEC : r_nd;
        w_err = !(w_pos || w_neg || r_sd == '0);
    end
    // DIFF stage registers the raw differences, NORM stage registers the folded result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sd  <= '0;
            r_nd  <= '0;
            r_ns  <= '0;
            r_err <= 1'b0;
        end else begin
            r_sd  <= w_sd;
            r_nd  <= w_nd;
            r_ns  <= w_ns;
            r_err <= w_err;
        end
    end
    assign o_ns        = r_ns;
    assign o_range_err = r_err;
endmodule

// File: rtl/ptp_pdelay_calc.sv
// ptp_pdelay_calc: 802.1AS mean link delay with sample qualification, IIR smoothing and asCapable
module ptp_pdelay_calc
    import ptp_pkg::*;
#(
    parameter int          TIMESTAMP_WIDTH = 80,
    parameter logic [31:0] DELAY_THRESH    = 32'd800,
    parameter int          FILT_SHIFT      = 3,
    parameter int          ACCEPT_CNT      = 3
) (
    input logic i_clk,
    input logic i_rst,
    ptp_pdelay_calc_if.slave bus
);
    localparam int ACCW = 32 + FILT_SHIFT;
    localparam int CW   = $clog2(ACCEPT_CNT + 1);
    state_t r_state, w_next;
    logic [TIMESTAMP_WIDTH-1:0] r_t0, r_t1, r_t2, r_t3;
    logic signed [32:0] w_a, w_b;
    logic w_err_a, w_err_b;
    logic signed [33:0] w_d, w_raw;
    logic [1:0] w_code, r_code, r_out_code;
    logic [31:0] r_raw, r_out_raw, r_time;
    logic [ACCW-1:0] r_acc, w_acc;
    logic [CW-1:0] r_cnt;
    logic r_first, r_valid, r_reject, r_overrun;
    ptp_ts_diff_ns #(.TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)) u_diff_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_ts_late(r_t3), .i_ts_early(r_t0),
        .o_ns(w_a), .o_range_err(w_err_a)
    );
    ptp_ts_diff_ns #(.TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)) u_diff_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_ts_late(r_t2), .i_ts_early(r_t1),
        .o_ns(w_b), .o_range_err(w_err_b)
    );
    // state register
    always_ff @(posedge i_clk) r_state <= i_rst ? S_IDLE : w_next;
    // fixed one-cycle-per-state walk once a sample is captured
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = bus.i_pdelaytime_valid ? S_DIFF : S_IDLE;
            S_DIFF:  w_next = S_NORM;
            S_NORM:  w_next = S_CHK;
            S_CHK:   w_next = S_FILT;
            default: w_next = S_IDLE;
        endcase
    end
    // halve the round trip minus turnaround, classify, and form the next filter value
    always_comb begin
        w_d    = {w_a[32], w_a} - {w_b[32], w_b};
        w_raw  = w_d >>> 1;
        w_code = (w_err_a || w_err_b) ? REJ_RANGE :
                 w_raw[33] ? REJ_NEG :
                 (w_raw > 34'(DELAY_THRESH)) ? REJ_THRESH : REJ_NONE;
        w_acc  = r_first ? ACCW'(r_raw) << FILT_SHIFT
                         : r_acc + ACCW'(r_raw) - (r_acc >> FILT_SHIFT);
    end
    // timestamps are only sampled when idle so a dropped strobe cannot disturb the in-flight sample
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && bus.i_pdelaytime_valid) begin
            r_t0 <= bus.i_pdelay_t0;
            r_t1 <= bus.i_pdelay_t1;
            r_t2 <= bus.i_pdelay_t2;
            r_t3 <= bus.i_pdelay_t3;
        end
    end
    // CHK/FILT results, IIR accumulator, accept counter and output pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code     <= REJ_NONE;
            r_raw      <= '0;
            r_out_code <= REJ_NONE;
            r_out_raw  <= '0;
            r_time     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_valid    <= 1'b0;
            r_reject   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= bus.i_pdelaytime_valid && r_state != S_IDLE;
            r_valid   <= r_state == S_FILT && r_code == REJ_NONE;
            r_reject  <= r_state == S_FILT && r_code != REJ_NONE;
            if (r_state == S_CHK) begin
                r_raw  <= 32'(w_raw);
                r_code <= w_code;
            end
            if (r_state == S_FILT) begin
                r_out_raw  <= r_raw;
                r_out_code <= r_code;
                if (r_code == REJ_NONE) begin
                    r_acc   <= w_acc;
                    r_time  <= 32'(w_acc >> FILT_SHIFT);
                    r_first <= 1'b0;
                    r_cnt   <= (r_cnt == CW'(ACCEPT_CNT)) ? r_cnt : r_cnt + CW'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end
    assign bus.o_pdelay_time       = r_time;
    assign bus.o_pdelay_time_valid = r_valid;
    assign bus.o_raw_delay         = r_out_raw;
    assign bus.o_sample_reject     = r_reject;
    assign bus.o_reject_code       = r_out_code;
    assign bus.o_as_capable        = r_cnt == CW'(ACCEPT_CNT);
    assign bus.o_overrun           = r_overrun;
    assign bus.o_busy              = r_state != S_IDLE;
endmodule

// File: tb/tb_ptp_pdelay_calc.sv
// tb_ptp_pdelay_calc: directed vector table plus overrun/reset sequences for the Pdelay calculator
module tb_ptp_pdelay_calc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2 clk = ~clk;
    ptp_pdelay_calc_if #(.TIMESTAMP_WIDTH(80)) bus ();
    ptp_pdelay_calc #(
        .TIMESTAMP_WIDTH(80), .DELAY_THRESH(32'd800), .FILT_SHIFT(3), .ACCEPT_CNT(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    typedef struct {
        logic [47:0] s0; logic [31:0] n0;
        logic [47:0] s1; logic [31:0] n1;
        logic [47:0] s2; logic [31:0] n2;
        logic [47:0] s3; logic [31:0] n3;
        logic [1:0]  code;
        logic        chk_raw;
        logic [31:0] raw;
        logic [31:0] ptime;
        logic        cap;
    } vec_t;
    vec_t vecs[10];
    vec_t v_basic, v_380, v_900;
    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input vec_t v);
        bus.i_pdelay_t0 = {v.s0, v.n0};
        bus.i_pdelay_t1 = {v.s1, v.n1};
        bus.i_pdelay_t2 = {v.s2, v.n2};
        bus.i_pdelay_t3 = {v.s3, v.n3};
        bus.i_pdelaytime_valid = 1'b1;
        tick();
        bus.i_pdelaytime_valid = 1'b0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_time"}, bus.o_pdelay_time, 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_pdelay_time_valid), 32'd0);
        chk({tag, "_raw"}, bus.o_raw_delay, 32'd0);
        chk({tag, "_rej"}, 32'(bus.o_sample_reject), 32'd0);
        chk({tag, "_code"}, 32'(bus.o_reject_code), 32'd0);
        chk({tag, "_cap"}, 32'(bus.o_as_capable), 32'd0);
        chk({tag, "_ovr"}, 32'(bus.o_overrun), 32'd0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    endtask
    initial begin
        vecs[0] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd1100, 2'd0, 1'b1, 32'd300, 32'd300, 1'b0};
        vecs[1] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd1260, 2'd0, 1'b1, 32'd380, 32'd310, 1'b0};
        vecs[2] = '{48'd10, 32'd999_999_900, 48'd5, 32'd999_999_950, 48'd6, 32'd50, 48'd11, 32'd200, 2'd0, 1'b1, 32'd100, 32'd283, 1'b1};
        vecs[3] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd199, 2'd1, 1'b1, 32'hFFFF_FF69, 32'd283, 1'b0};
        vecs[4] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd2300, 2'd2, 1'b1, 32'd900, 32'd283, 1'b0};
        vecs[5] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd12, 32'd1100, 2'd3, 1'b0, 32'd0, 32'd283, 1'b0};
        vecs[6] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd1100, 2'd0, 1'b1, 32'd300, 32'd285, 1'b0};
        vecs[7] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd2100, 2'd0, 1'b1, 32'd800, 32'd350, 1'b0};
        vecs[8] = '{48'hFFFF_FFFF_FFFF, 32'd999_999_900, 48'd5, 32'd999_999_950, 48'd6, 32'd50, 48'd0, 32'd200, 2'd0, 1'b1, 32'd100, 32'd319, 1'b1};
        vecs[9] = '{48'd10, 32'd100, 48'd5, 32'd1000, 48'd5, 32'd1400, 48'd10, 32'd2102, 2'd2, 1'b1, 32'd801, 32'd319, 1'b0};
        v_basic = vecs[0];
        v_380   = vecs[1];
        v_900   = vecs[4];
        bus.i_pdelay_t0 = '0;
        bus.i_pdelay_t1 = '0;
        bus.i_pdelay_t2 = '0;
        bus.i_pdelay_t3 = '0;
        bus.i_pdelaytime_valid = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            chk($sformatf("v%0d_busy_c1", i), 32'(bus.o_busy), 32'd1);
            chk($sformatf("v%0d_nopulse_c1", i), 32'(bus.o_pdelay_time_valid | bus.o_sample_reject), 32'd0);
            repeat (4) tick();
            chk($sformatf("v%0d_busy_c5", i), 32'(bus.o_busy), 32'd0);
            chk($sformatf("v%0d_valid", i), 32'(bus.o_pdelay_time_valid), 32'(vecs[i].code == 2'd0));
            chk($sformatf("v%0d_reject", i), 32'(bus.o_sample_reject), 32'(vecs[i].code != 2'd0));
            chk($sformatf("v%0d_code", i), 32'(bus.o_reject_code), 32'(vecs[i].code));
            chk($sformatf("v%0d_time", i), bus.o_pdelay_time, vecs[i].ptime);
            chk($sformatf("v%0d_cap", i), 32'(bus.o_as_capable), 32'(vecs[i].cap));
            if (vecs[i].chk_raw) chk($sformatf("v%0d_raw", i), bus.o_raw_delay, vecs[i].raw);
        end
        // overrun: second strobe at cycle 2 is dropped
        drive(v_basic);
        tick();
        bus.i_pdelay_t0 = {v_900.s0, v_900.n0};
        bus.i_pdelay_t1 = {v_900.s1, v_900.n1};
        bus.i_pdelay_t2 = {v_900.s2, v_900.n2};
        bus.i_pdelay_t3 = {v_900.s3, v_900.n3};
        bus.i_pdelaytime_valid = 1'b1;
        chk("ovr_c2", 32'(bus.o_overrun), 32'd0);
        tick();
        bus.i_pdelaytime_valid = 1'b0;
        chk("ovr_c3", 32'(bus.o_overrun), 32'd1);
        tick();
        chk("ovr_c4", 32'(bus.o_overrun), 32'd0);
        tick();
        chk("ovr_valid", 32'(bus.o_pdelay_time_valid), 32'd1);
        chk("ovr_raw", bus.o_raw_delay, 32'd300);
        chk("ovr_time", bus.o_pdelay_time, 32'd316);
        for (int c = 6; c < 12; c++) begin
            tick();
            chk($sformatf("ovr_nopulse_c%0d", c), 32'(bus.o_pdelay_time_valid | bus.o_sample_reject), 32'd0);
        end
        chk("ovr_raw_hold", bus.o_raw_delay, 32'd300);
        // reset asserted at cycle 3 aborts the sample
        drive(v_380);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst_c4");
        tick();
        chk_zero("midrst_c5");
        drive(v_380);
        repeat (4) tick();
        chk("post_rst_valid", 32'(bus.o_pdelay_time_valid), 32'd1);
        chk("post_rst_time", bus.o_pdelay_time, 32'd380);
        chk("post_rst_raw", bus.o_raw_delay, 32'd380);
        chk("post_rst_cap", 32'(bus.o_as_capable), 32'd0);
        // reset wins over a simultaneous strobe
        bus.i_pdelay_t0 = {v_basic.s0, v_basic.n0};
        bus.i_pdelay_t1 = {v_basic.s1, v_basic.n1};
        bus.i_pdelay_t2 = {v_basic.s2, v_basic.n2};
        bus.i_pdelay_t3 = {v_basic.s3, v_basic.n3};
        bus.i_pdelaytime_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_pdelaytime_valid = 1'b0;
        chk_zero("rst_prio_c1");
        for (int c = 2; c < 8; c++) begin
            tick();
            chk($sformatf("rst_prio_nopulse_c%0d", c), 32'(bus.o_pdelay_time_valid | bus.o_sample_reject | bus.o_busy), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ptp_pdelay_calc.md
# ptp_pdelay_calc

Computes the IEEE 802.1AS peer (link) delay for one port from the four Pdelay timestamps t0..t3 delivered by the PTP time register list. It rejects implausible samples and smooths accepted ones with a first-order IIR filter. It qualifies the link (asCapable) and returns the filtered mean link delay to the register list as the 32-bit path-delay result. Downstream consumers are the clock-offset path and correctionField insertion.

## Interface
- TIMESTAMP_WIDTH, 80, timestamp width: [79:32] = 48-bit seconds, [31:0] = nanoseconds (< 1e9)
- DELAY_THRESH, 32'd800, neighborPropDelayThresh in ns; accepted delay must be ≤ this
- FILT_SHIFT, 3, IIR weight 2^-FILT_SHIFT
- ACCEPT_CNT, 3, consecutive accepted samples required to raise asCapable

Ports:
- i_clk  in  1  single clock, 250 MHz
- i_rst  in  1  synchronous, active-high reset
- i_pdelay_t0 / _t1 / _t2 / _t3  in  TIMESTAMP_WIDTH each  req egress / req ingress at peer / resp egress at peer / resp ingress
- i_pdelaytime_valid  in  1  single-cycle strobe; all four timestamps are valid in this cycle
- o_pdelay_time  out  32  filtered mean link delay, ns
- o_pdelay_time_valid  out  1  single-cycle pulse when o_pdelay_time has been updated
- o_raw_delay  out  32  most recent unfiltered delay (low 32 bits of the signed value), updated for every processed sample
- o_sample_reject  out  1  single-cycle pulse when a sample is rejected
- o_reject_code  out  2  01 negative, 10 above threshold, 11 seconds difference out of range; held until the next processed sample
- o_as_capable  out  1  link qualified
- o_overrun  out  1  single-cycle pulse when a strobe is dropped because the block is busy
- o_busy  out  1  state ≠ IDLE

## Operation
- State machine: IDLE → DIFF → NORM → CHK → FILT → IDLE. Each state lasts exactly one cycle.
- IDLE: on i_pdelaytime_valid, capture t0..t3 and go to DIFF.
- DIFF: compute sd_A = sec(t3) − sec(t0) and sd_B = sec(t2) − sec(t1), 48-bit two's complement. Compute nd_A and nd_B the same way from the ns fields, 33-bit signed.
- NORM: A = nd_A + sd_A·1e9 and B = nd_B + sd_B·1e9, 33-bit signed. Only sd ∈ {−1, 0, +1} is supported, so the product reduces to add or subtract of NS_PER_SEC; no multiplier. Any other sd sets range_err.
- CHK: D = A − B (34-bit signed), raw = D >>> 1 (arithmetic shift, truncate). Reject priority: range_err (11) > raw < 0 (01) > raw > DELAY_THRESH (10).
- FILT, accepted sample:
  - First accepted sample since reset: acc = raw << FILT_SHIFT.
  - Otherwise: acc = acc + raw − (acc >> FILT_SHIFT).
  - acc is 32+FILT_SHIFT bits, unsigned. o_pdelay_time = acc >> FILT_SHIFT.
- FILT, rejected sample: acc and o_pdelay_time hold.
- Accept counter: increments on each accept, saturating at ACCEPT_CNT. o_as_capable = (count == ACCEPT_CNT). Any reject clears the counter and o_as_capable.
- Strobe while busy: dropped, o_overrun pulses the next cycle, and the in-flight sample is unaffected.

## Timing
- Strobe at cycle 0 produces o_pdelay_time_valid or o_sample_reject at cycle 5; exactly one of the two pulses.
- o_raw_delay and o_reject_code update at cycle 5.
- o_busy is high in cycles 1–4. A strobe at cycle 5 is accepted, giving a throughput of 1 sample per 5 cycles.
- Reset: all outputs 0, state IDLE, acc 0, first-sample flag set, accept counter 0.
- Reset mid-operation aborts the sample; no pulse is generated for it.
- Reset has priority over a strobe in the same cycle.
- Seconds wrap between t0/t3 or between t1/t2 is handled through sd = ±1. A 48-bit wrap is handled naturally by two's-complement subtraction.

## Structure
- Shared package ptp_pkg holds NS_PER_SEC = 1_000_000_000, the reject-code constants and the FSM state encoding.
- One sub-module, ptp_ts_diff_ns, computes a TIMESTAMP_WIDTH difference as a 33-bit signed ns value plus range_err. It is registered internally across DIFF/NORM (two-cycle latency) and instantiated twice, for A and B.

## Test plan
- Basic sample. t0 = {10, 100}, t1 = {5, 1000}, t2 = {5, 1400}, t3 = {10, 1100}. Expect at cycle 5: A = 1000, B = 400, o_raw_delay = 300, o_pdelay_time = 300 with valid pulse.
- IIR update. Follow the basic sample with one giving raw = 380. Expect acc = 2480 and o_pdelay_time = 310. After 3 accepts, o_as_capable = 1.
- Seconds wrap. t0 = {10, 999_999_900}, t3 = {11, 200}, t1 = {5, 999_999_950}, t2 = {6, 50}. Expect raw = 100 and the sample accepted.
- Rejects:
  - A = 100, B = 400: code 01, o_pdelay_time holds, o_as_capable drops.
  - raw = 900: code 10.
  - sec(t3) − sec(t0) = 2: code 11.
- Overrun. Second strobe at cycle 2: o_overrun pulses at cycle 3, the first result is correct at cycle 5, and no second result is produced.
- Reset mid-operation. Assert i_rst at cycle 3: no pulse at cycle 5 and all outputs 0. The next sample loads acc directly, so output = raw.
